// File: rtl/input_cond_pkg.sv
// Shared constants and helpers for the input conditioner.
package input_cond_pkg;

  localparam int unsigned N_IN_DEFAULT = 6;

  // Debounce hold time in clock cycles (CNT_MAX), never less than 1.
  // The product is formed in 64 bits so large clocks / long windows cannot overflow.
  function automatic int unsigned debounce_cycles(input longint unsigned f_clk_hz,
                                                   input longint unsigned ms);
    longint unsigned cycles;
    cycles = (f_clk_hz / 64'd1000) * ms;
    if (cycles < 64'd1) cycles = 64'd1;
    return 32'(cycles);
  endfunction

endpackage

// File: rtl/input_conditioner_channel.sv
// One input bit: synchroniser, counter debouncer and rise/fall strobes.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s                        polarity-normalised asynchronous level
//   clean                    debounced level
//   rise_pulse, fall_pulse   registered one-cycle strobes on clean edges
//   rise_next_c, fall_next_c strobe values that will be registered at the next edge
module debounce_channel
  import input_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_MAX     = 4,
  parameter int unsigned CNT_W       = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  output logic clean,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic rise_next_c,
  output logic fall_next_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   clean_d;
  logic                   sy;

  assign sy = sync_q[SYNC_STAGES-1];

  // Synchroniser chain; stage 0 takes the raw (asynchronous) level.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], s};
  end

  // Accept a new level only after CNT_MAX consecutive disagreeing cycles.
  always_comb begin
    cnt_d       = cnt_q;
    clean_d     = clean;
    rise_next_c = 1'b0;
    fall_next_c = 1'b0;
    if (sy == clean) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(CNT_MAX - 1)) begin
      cnt_d       = '0;
      clean_d     = sy;
      rise_next_c = sy;
      fall_next_c = ~sy;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Debounce state and strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      clean      <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      clean      <= clean_d;
      rise_pulse <= rise_next_c;
      fall_pulse <= fall_next_c;
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Conditions raw switch/button pins: polarity fix, synchronise, debounce, edge strobes.
// Ports:
//   clk         system clock (rising edge)
//   rst         synchronous reset, active-high
//   raw_in      asynchronous pin levels, bit 0 = in_a
//   clean_out   debounced logical level (1 = asserted)
//   rise_pulse  one-cycle strobe on clean_out 0->1
//   fall_pulse  one-cycle strobe on clean_out 1->0
//   any_change  OR of all strobes, aligned with them
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int unsigned N_IN        = N_IN_DEFAULT,
  parameter bit          ACTIVE_LOW  = 1'b0,
  parameter int unsigned F_CLK_HZ    = 25_000_000,
  parameter int unsigned DEBOUNCE_MS = 10,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] raw_in,
  output logic [N_IN-1:0] clean_out,
  output logic [N_IN-1:0] rise_pulse,
  output logic [N_IN-1:0] fall_pulse,
  output logic            any_change
);

  localparam int unsigned CNT_MAX = debounce_cycles(64'(F_CLK_HZ), 64'(DEBOUNCE_MS));
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  logic [N_IN-1:0] s;
  logic [N_IN-1:0] rise_next_c;
  logic [N_IN-1:0] fall_next_c;

  // Inversion happens before synchronisation so downstream logic is active-high.
  assign s = ACTIVE_LOW ? ~raw_in : raw_in;

  for (genvar i = 0; i < int'(N_IN); i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_MAX    (CNT_MAX),
      .CNT_W      (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .s          (s[i]),
      .clean      (clean_out[i]),
      .rise_pulse (rise_pulse[i]),
      .fall_pulse (fall_pulse[i]),
      .rise_next_c(rise_next_c[i]),
      .fall_next_c(fall_next_c[i])
    );
  end

  // Registered from the next-strobe values so it lines up with the strobe registers.
  always_ff @(posedge clk) begin
    if (rst) any_change <= 1'b0;
    else     any_change <= |(rise_next_c | fall_next_c);
  end

endmodule
